// File: rtl/attitude_sched.sv
// attitude_sched: fixed-rate attitude update sequencer.
// Each tick it requests an IMU sample, integrates gyro rates onto the last
// fused attitude, strobes cmp_filter, captures the filter result and
// publishes it. The published att_* registers double as the fused state.
module attitude_sched #(
  parameter int TICK_DIV   = 100000,
  parameter int TIMEOUT    = 50000,
  parameter int RATE_SHIFT = 10,
  parameter int FILT_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sched_en,
  output logic        imu_req,
  input  logic        imu_done,
  input  logic        imu_err,
  input  logic [15:0] gyro_x,
  input  logic [15:0] gyro_y,
  input  logic [15:0] gyro_z,
  input  logic [23:0] acc_pitch,
  input  logic [23:0] acc_roll,
  output logic        cmp_filter_en,
  output logic [23:0] cur_pitch_gyro,
  output logic [23:0] cur_roll_gyro,
  output logic [23:0] cur_yaw_gyro,
  output logic [23:0] cur_pitch_acc,
  output logic [23:0] cur_roll_acc,
  input  logic [23:0] cur_pitch,
  input  logic [23:0] cur_roll,
  input  logic [23:0] cur_yaw,
  output logic [23:0] att_pitch,
  output logic [23:0] att_roll,
  output logic [23:0] att_yaw,
  output logic        att_valid,
  output logic [7:0]  overrun_cnt,
  output logic        timeout_err,
  output logic [7:0]  skip_cnt
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int OW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(FILT_LAT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [OW-1:0] TO_LAST   = OW'(TIMEOUT - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_REQ,
    S_WAIT_IMU,
    S_INTEG,
    S_FILT,
    S_WAIT_FILT,
    S_PUBLISH
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [OW-1:0] to_cnt_q, to_cnt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          tick;

  logic [15:0] gyro_x_q, gyro_x_d, gyro_y_q, gyro_y_d, gyro_z_q, gyro_z_d;
  logic [23:0] acc_pitch_q, acc_pitch_d, acc_roll_q, acc_roll_d;
  logic [23:0] cur_pitch_gyro_q, cur_pitch_gyro_d;
  logic [23:0] cur_roll_gyro_q, cur_roll_gyro_d;
  logic [23:0] cur_yaw_gyro_q, cur_yaw_gyro_d;
  logic [23:0] cur_pitch_acc_q, cur_pitch_acc_d;
  logic [23:0] cur_roll_acc_q, cur_roll_acc_d;
  logic [23:0] att_pitch_q, att_pitch_d, att_roll_q, att_roll_d, att_yaw_q, att_yaw_d;
  logic [7:0]  overrun_cnt_q, overrun_cnt_d, skip_cnt_q, skip_cnt_d;
  logic        timeout_err_q, timeout_err_d;

  // fused + (sign-extended rate >>> RATE_SHIFT), 25-bit sum saturated to 24 bits
  function automatic logic [23:0] integ(input logic [23:0] fused, input logic [15:0] rate);
    logic signed [24:0] step;
    logic signed [24:0] sum;
    step = 25'($signed(rate));
    step = step >>> RATE_SHIFT;
    sum  = $signed({fused[23], fused}) + step;
    if (sum[24] != sum[23]) integ = sum[24] ? 24'h800000 : 24'h7FFFFF;
    else                    integ = sum[23:0];
  endfunction

  // Tick divider: free-runs while enabled, parked at 0 otherwise
  always_comb begin
    tick       = 1'b0;
    tick_cnt_d = '0;
    if (sched_en) begin
      if (tick_cnt_q == TICK_LAST) tick = 1'b1;
      else                         tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  // Next-state, datapath updates and strobes
  always_comb begin
    state_d          = state_q;
    to_cnt_d         = to_cnt_q;
    filt_cnt_d       = filt_cnt_q;
    gyro_x_d         = gyro_x_q;
    gyro_y_d         = gyro_y_q;
    gyro_z_d         = gyro_z_q;
    acc_pitch_d      = acc_pitch_q;
    acc_roll_d       = acc_roll_q;
    cur_pitch_gyro_d = cur_pitch_gyro_q;
    cur_roll_gyro_d  = cur_roll_gyro_q;
    cur_yaw_gyro_d   = cur_yaw_gyro_q;
    cur_pitch_acc_d  = cur_pitch_acc_q;
    cur_roll_acc_d   = cur_roll_acc_q;
    att_pitch_d      = att_pitch_q;
    att_roll_d       = att_roll_q;
    att_yaw_d        = att_yaw_q;
    overrun_cnt_d    = overrun_cnt_q;
    skip_cnt_d       = skip_cnt_q;
    timeout_err_d    = timeout_err_q;
    imu_req          = 1'b0;
    cmp_filter_en    = 1'b0;
    att_valid        = (state_q == S_PUBLISH);

    if (tick && state_q != S_WAIT_TICK && overrun_cnt_q != 8'hFF)
      overrun_cnt_d = overrun_cnt_q + 8'd1;

    // Disabling aborts everything in flight; only the tick/overrun path above
    // can act, and it is itself gated by sched_en.
    if (!sched_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      state_d = S_WAIT_TICK;
        S_WAIT_TICK: if (tick) state_d = S_REQ;
        S_REQ: begin
          imu_req  = 1'b1;
          to_cnt_d = '0;
          state_d  = S_WAIT_IMU;
        end
        S_WAIT_IMU: begin
          if (imu_done) begin
            if (imu_err) begin
              if (skip_cnt_q != 8'hFF) skip_cnt_d = skip_cnt_q + 8'd1;
              state_d = S_WAIT_TICK;
            end else begin
              gyro_x_d    = gyro_x;
              gyro_y_d    = gyro_y;
              gyro_z_d    = gyro_z;
              acc_pitch_d = acc_pitch;
              acc_roll_d  = acc_roll;
              state_d     = S_INTEG;
            end
          end else if (to_cnt_q == TO_LAST) begin
            timeout_err_d = 1'b1;
            state_d       = S_WAIT_TICK;
          end else begin
            to_cnt_d = to_cnt_q + OW'(1);
          end
        end
        S_INTEG: begin
          cur_pitch_gyro_d = integ(att_pitch_q, gyro_x_q);
          cur_roll_gyro_d  = integ(att_roll_q, gyro_y_q);
          cur_yaw_gyro_d   = integ(att_yaw_q, gyro_z_q);
          cur_pitch_acc_d  = acc_pitch_q;
          cur_roll_acc_d   = acc_roll_q;
          state_d          = S_FILT;
        end
        S_FILT: begin
          cmp_filter_en = 1'b1;
          filt_cnt_d    = '0;
          state_d       = S_WAIT_FILT;
        end
        S_WAIT_FILT: begin
          if (filt_cnt_q == FILT_LAST) begin
            att_pitch_d = cur_pitch;
            att_roll_d  = cur_roll;
            att_yaw_d   = cur_yaw;
            state_d     = S_PUBLISH;
          end else begin
            filt_cnt_d = filt_cnt_q + FW'(1);
          end
        end
        S_PUBLISH:   state_d = S_WAIT_TICK;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      tick_cnt_q       <= '0;
      to_cnt_q         <= '0;
      filt_cnt_q       <= '0;
      gyro_x_q         <= '0;
      gyro_y_q         <= '0;
      gyro_z_q         <= '0;
      acc_pitch_q      <= '0;
      acc_roll_q       <= '0;
      cur_pitch_gyro_q <= '0;
      cur_roll_gyro_q  <= '0;
      cur_yaw_gyro_q   <= '0;
      cur_pitch_acc_q  <= '0;
      cur_roll_acc_q   <= '0;
      att_pitch_q      <= '0;
      att_roll_q       <= '0;
      att_yaw_q        <= '0;
      overrun_cnt_q    <= '0;
      skip_cnt_q       <= '0;
      timeout_err_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      tick_cnt_q       <= tick_cnt_d;
      to_cnt_q         <= to_cnt_d;
      filt_cnt_q       <= filt_cnt_d;
      gyro_x_q         <= gyro_x_d;
      gyro_y_q         <= gyro_y_d;
      gyro_z_q         <= gyro_z_d;
      acc_pitch_q      <= acc_pitch_d;
      acc_roll_q       <= acc_roll_d;
      cur_pitch_gyro_q <= cur_pitch_gyro_d;
      cur_roll_gyro_q  <= cur_roll_gyro_d;
      cur_yaw_gyro_q   <= cur_yaw_gyro_d;
      cur_pitch_acc_q  <= cur_pitch_acc_d;
      cur_roll_acc_q   <= cur_roll_acc_d;
      att_pitch_q      <= att_pitch_d;
      att_roll_q       <= att_roll_d;
      att_yaw_q        <= att_yaw_d;
      overrun_cnt_q    <= overrun_cnt_d;
      skip_cnt_q       <= skip_cnt_d;
      timeout_err_q    <= timeout_err_d;
    end
  end

  assign cur_pitch_gyro = cur_pitch_gyro_q;
  assign cur_roll_gyro  = cur_roll_gyro_q;
  assign cur_yaw_gyro   = cur_yaw_gyro_q;
  assign cur_pitch_acc  = cur_pitch_acc_q;
  assign cur_roll_acc   = cur_roll_acc_q;
  assign att_pitch      = att_pitch_q;
  assign att_roll       = att_roll_q;
  assign att_yaw        = att_yaw_q;
  assign overrun_cnt    = overrun_cnt_q;
  assign skip_cnt       = skip_cnt_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_attitude_sched.sv
// Bench for attitude_sched. Two instances share the IMU-side inputs; only one
// has sched_en high at a time. Instance a: TICK_DIV=20, TIMEOUT=64,
// RATE_SHIFT=10. Instance b: TICK_DIV=20, TIMEOUT=8, RATE_SHIFT=0.
// The filter model is a pass-through of cur_*_gyro.
module tb_attitude_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sched_a = 1'b0, sched_b = 1'b0;
  logic        imu_done = 1'b0, imu_err = 1'b0;
  logic [15:0] gyro_x = '0, gyro_y = '0, gyro_z = '0;
  logic [23:0] acc_pitch = '0, acc_roll = '0;

  logic        req_a, en_a, val_a, to_a;
  logic [23:0] pg_a, rg_a, yg_a, pa_a, ra_a, ap_a, ar_a, ay_a;
  logic [7:0]  ovr_a, skip_a;
  logic        req_b, en_b, val_b, to_b;
  logic [23:0] pg_b, rg_b, yg_b, pa_b, ra_b, ap_b, ar_b, ay_b;
  logic [7:0]  ovr_b, skip_b;

  always #5 clk = ~clk;

  attitude_sched #(.TICK_DIV(20), .TIMEOUT(64), .RATE_SHIFT(10), .FILT_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_a), .imu_req(req_a),
    .imu_done(imu_done), .imu_err(imu_err),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .acc_pitch(acc_pitch), .acc_roll(acc_roll), .cmp_filter_en(en_a),
    .cur_pitch_gyro(pg_a), .cur_roll_gyro(rg_a), .cur_yaw_gyro(yg_a),
    .cur_pitch_acc(pa_a), .cur_roll_acc(ra_a),
    .cur_pitch(pg_a), .cur_roll(rg_a), .cur_yaw(yg_a),
    .att_pitch(ap_a), .att_roll(ar_a), .att_yaw(ay_a), .att_valid(val_a),
    .overrun_cnt(ovr_a), .timeout_err(to_a), .skip_cnt(skip_a));

  attitude_sched #(.TICK_DIV(20), .TIMEOUT(8), .RATE_SHIFT(0), .FILT_LAT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_b), .imu_req(req_b),
    .imu_done(imu_done), .imu_err(imu_err),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .acc_pitch(acc_pitch), .acc_roll(acc_roll), .cmp_filter_en(en_b),
    .cur_pitch_gyro(pg_b), .cur_roll_gyro(rg_b), .cur_yaw_gyro(yg_b),
    .cur_pitch_acc(pa_b), .cur_roll_acc(ra_b),
    .cur_pitch(pg_b), .cur_roll(rg_b), .cur_yaw(yg_b),
    .att_pitch(ap_b), .att_roll(ar_b), .att_yaw(ay_b), .att_valid(val_b),
    .overrun_cnt(ovr_b), .timeout_err(to_b), .skip_cnt(skip_b));

  wire [211:0] all_a = {req_a, en_a, pg_a, rg_a, yg_a, pa_a, ra_a, ap_a, ar_a, ay_a,
                        val_a, ovr_a, to_a, skip_a};
  wire [211:0] all_b = {req_b, en_b, pg_b, rg_b, yg_b, pa_b, ra_b, ap_b, ar_b, ay_b,
                        val_b, ovr_b, to_b, skip_b};

  int n_vec = 0, n_mis = 0;
  int cyc = 0;
  int en_cnt_a = 0, val_cnt_a = 0, en_cnt_b = 0, val_cnt_b = 0;
  int last_val_a = 0, prev_val_a = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (en_a) en_cnt_a++;
    if (val_a) begin val_cnt_a++; prev_val_a = last_val_a; last_val_a = cyc; end
    if (en_b) en_cnt_b++;
    if (val_b) val_cnt_b++;
  end

  typedef struct {
    logic [15:0] gx, gy, gz;
    logic [23:0] ap, ar;
    int dly; bit err;
    int e_pg, e_rg, e_yg, e_ap, e_ar, e_ovr, e_skip;
    bit per;
  } vec_t;

  function automatic vec_t mk(int gx, int gy, int gz, int ap, int ar, int dly, bit err,
                              int pg, int rg, int yg, int eap, int ear, int ovr,
                              int skip, bit per);
    vec_t v;
    v.gx = 16'(gx); v.gy = 16'(gy); v.gz = 16'(gz);
    v.ap = 24'(ap); v.ar = 24'(ar);
    v.dly = dly; v.err = err;
    v.e_pg = pg; v.e_rg = rg; v.e_yg = yg; v.e_ap = eap; v.e_ar = ear;
    v.e_ovr = ovr; v.e_skip = skip; v.per = per;
    return v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_req(input bit sel_b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (sel_b ? req_b : req_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(input bit sel_b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (sel_b ? val_b : val_a) begin ok = 1'b1; break; end
    end
  endtask

  // imu_done lands dly cycles after the imu_req cycle
  task automatic respond(input int dly, input bit err, input logic [15:0] gx,
                         input logic [15:0] gy, input logic [15:0] gz,
                         input logic [23:0] ap, input logic [23:0] ar);
    repeat (dly) step();
    gyro_x = gx; gyro_y = gy; gyro_z = gz; acc_pitch = ap; acc_roll = ar;
    imu_done = 1'b1; imu_err = err;
    step();
    imu_done = 1'b0; imu_err = 1'b0;
  endtask

  vec_t vt[6];

  initial begin
    bit ok;
    int e0, v0, k_first;
    longint exp_r;

    vt[0] = mk(1024,      0,     0, 100, -200,  3, 0, 1,  0,  0, 100, -200, 0, 0, 0);
    vt[1] = mk(1024,   2048, -1024,   5,    6,  3, 0, 2,  2, -1,   5,    6, 0, 0, 1);
    vt[2] = mk(1024,  -3072,  1023,  -7,    8,  3, 0, 3, -1, -1,  -7,    8, 0, 0, 1);
    vt[3] = mk(5000,   5000,  5000, 999,  999,  3, 1, 3, -1, -1,  -7,    8, 0, 1, 0);
    vt[4] = mk(  -1,   1025, -1025,   0,   -1,  3, 0, 2,  0, -3,   0,   -1, 0, 1, 0);
    vt[5] = mk(   0,      0,     0,   1,    2, 45, 0, 2,  0, -3,   1,    2, 2, 1, 0);

    repeat (3) step();
    rst_n = 1'b1;
    chk("reset_a_bits", $countones(all_a), 0);
    chk("reset_b_bits", $countones(all_b), 0);

    // Table-driven updates on instance a
    sched_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e0 = en_cnt_a; v0 = val_cnt_a;
      wait_req(1'b0, ok);
      chk($sformatf("v%0d_imu_req", i), ok, 1);
      respond(vt[i].dly, vt[i].err, vt[i].gx, vt[i].gy, vt[i].gz, vt[i].ap, vt[i].ar);
      if (!vt[i].err) begin
        wait_valid(1'b0, ok);
        chk($sformatf("v%0d_att_valid_seen", i), ok, 1);
        step();
      end else begin
        repeat (8) step();
      end
      chk($sformatf("v%0d_pitch_gyro", i), longint'($signed(pg_a)), vt[i].e_pg);
      chk($sformatf("v%0d_roll_gyro", i),  longint'($signed(rg_a)), vt[i].e_rg);
      chk($sformatf("v%0d_yaw_gyro", i),   longint'($signed(yg_a)), vt[i].e_yg);
      chk($sformatf("v%0d_att_pitch", i),  longint'($signed(ap_a)), vt[i].e_pg);
      chk($sformatf("v%0d_att_roll", i),   longint'($signed(ar_a)), vt[i].e_rg);
      chk($sformatf("v%0d_att_yaw", i),    longint'($signed(ay_a)), vt[i].e_yg);
      chk($sformatf("v%0d_pitch_acc", i),  longint'($signed(pa_a)), vt[i].e_ap);
      chk($sformatf("v%0d_roll_acc", i),   longint'($signed(ra_a)), vt[i].e_ar);
      chk($sformatf("v%0d_overrun", i),    ovr_a, vt[i].e_ovr);
      chk($sformatf("v%0d_skip", i),       skip_a, vt[i].e_skip);
      chk($sformatf("v%0d_filt_en_pulses", i), en_cnt_a - e0, vt[i].err ? 0 : 1);
      chk($sformatf("v%0d_att_valid_pulses", i), val_cnt_a - v0, vt[i].err ? 0 : 1);
      if (vt[i].per) chk($sformatf("v%0d_period", i), last_val_a - prev_val_a, 20);
    end
    chk("a_timeout_err", to_a, 0);

    // Timeout on instance b: no imu_done at all
    sched_a = 1'b0;
    sched_b = 1'b1;
    wait_req(1'b1, ok);
    chk("b_first_req", ok, 1);
    k_first = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (to_b && k_first == 0) k_first = k;
    end
    chk("b_timeout_cycle", k_first, 9);
    chk("b_timeout_no_filt_en", en_cnt_b, 0);

    // Roll saturation on instance b (RATE_SHIFT=0, -32768 per update)
    for (int k = 1; k <= 258; k++) begin
      wait_req(1'b1, ok);
      chk($sformatf("b_sat%0d_req", k), ok, 1);
      respond(1, 1'b0, 16'd0, 16'h8000, 16'd0, 24'd0, 24'd0);
      wait_valid(1'b1, ok);
      chk($sformatf("b_sat%0d_valid", k), ok, 1);
      exp_r = -32768 * longint'(k);
      if (exp_r < -8388608) exp_r = -8388608;
      chk($sformatf("b_sat%0d_roll_gyro", k), longint'($signed(rg_b)), exp_r);
    end
    chk("b_timeout_sticky", to_b, 1);
    chk("b_filt_en_total", en_cnt_b, 258);

    // Instance a idle throughout: shared imu_done traffic ignored
    chk("a_idle_skip", skip_a, 1);
    chk("a_idle_pitch_gyro", longint'($signed(pg_a)), 2);

    // sched_en dropped in WAIT_FILT: filter strobed once, no capture, no publish
    sched_b = 1'b0;
    sched_a = 1'b1;
    e0 = en_cnt_a; v0 = val_cnt_a;
    wait_req(1'b0, ok);
    chk("drop_req", ok, 1);
    respond(3, 1'b0, 16'd1024, 16'd0, 16'd0, 24'd0, 24'd0);
    step();
    chk("drop_filt_en_now", en_a, 1);
    step();
    sched_a = 1'b0;
    repeat (5) step();
    chk("drop_no_att_valid", val_cnt_a - v0, 0);
    chk("drop_att_pitch_held", longint'($signed(ap_a)), 2);
    chk("drop_pitch_gyro", longint'($signed(pg_a)), 3);
    chk("drop_filt_en_pulses", en_cnt_a - e0, 1);

    // Reset in WAIT_IMU
    sched_a = 1'b1;
    wait_req(1'b0, ok);
    chk("rst_req", ok, 1);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_a_bits", $countones(all_a), 0);
    chk("midrst_b_bits", $countones(all_b), 0);
    // stale errored response arrives while the instance sits in IDLE
    imu_done = 1'b1; imu_err = 1'b1;
    step();
    imu_done = 1'b0; imu_err = 1'b0;
    v0 = val_cnt_a;
    repeat (10) step();
    chk("post_rst_skip", skip_a, 0);
    chk("post_rst_no_valid", val_cnt_a - v0, 0);
    sched_a = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
